// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot byte-stream loader.
package mem_loader_pkg;

    localparam int LOADER_WORD_BYTES = 4;
    localparam int LOADER_WORD_W     = 8 * LOADER_WORD_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } loader_state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian 4x8 -> 32 word assembler shared by the header and payload phases.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     shift_en,
    input  logic [7:0]               byte_in,
    output logic [LOADER_WORD_W-1:0] word_nxt,
    output logic                     full,
    output logic                     last
);

    localparam int CNT_W = $clog2(LOADER_WORD_BYTES + 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_base;
    logic [LOADER_WORD_W-1:0] word_q, word_d;

    // clr and shift_en in the same cycle start a fresh word with this byte as byte 0.
    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        word_d   = word_q;
        if (shift_en) begin
            cnt_d  = cnt_base + CNT_W'(1);
            word_d = {byte_in, word_q[LOADER_WORD_W-1:8]};
        end
    end

    assign word_nxt = word_d;
    assign full     = (cnt_q == CNT_W'(LOADER_WORD_BYTES));
    assign last     = shift_en && (cnt_base == CNT_W'(LOADER_WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: turns a length-prefixed byte stream into word writes on the flash port.
// Optional trailing payload-XOR check is built when CHECKSUM_EN is defined.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               MAX_WORDS = 512
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // state | meaning
    // IDLE  | after reset, CPU held, waiting for start
    // HDR   | collecting the 4-byte word count
    // DATA  | collecting the 4 bytes of the next payload word
    // WRITE | one-cycle write strobe for the assembled word
    // CSUM  | collecting the trailing payload-XOR byte
    // DONE  | image loaded, CPU released
    // ERR   | bad header or checksum, CPU held

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    loader_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
    logic [WIDTH-1:0] flash_data_q, flash_data_d;
    logic             flash_en_q, flash_en_d;

    logic                     accept;
    logic                     pk_clr, pk_shift, pk_full, pk_last;
    logic [LOADER_WORD_W-1:0] pk_word_nxt;

`ifdef CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .shift_en (pk_shift),
        .byte_in  (in_data),
        .word_nxt (pk_word_nxt),
        .full     (pk_full),
        .last     (pk_last)
    );

    assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign accept   = in_valid && in_ready;
    assign busy     = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);

    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign flash_en   = flash_en_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        flash_addr_d = flash_addr_q;
        flash_data_d = flash_data_q;
        flash_en_d   = 1'b0;
        pk_clr       = pk_full;
        pk_shift     = 1'b0;
`ifdef CHECKSUM_EN
        csum_d       = csum_q;
`endif

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR;
                    idx_d   = '0;
                    pk_clr  = 1'b1;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            HDR: begin
                pk_shift = accept;
                if (pk_last) begin
                    if (pk_word_nxt == '0) begin
                        state_d = DONE;
                    end else if (pk_word_nxt > LOADER_WORD_W'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        n_d     = pk_word_nxt[IDX_W-1:0];
                    end
                end
            end

            // Outputs are registered on the 4th byte so the strobe lands in WRITE itself.
            DATA: begin
                pk_shift = accept;
`ifdef CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                end
`endif
                if (pk_last) begin
                    state_d      = WRITE;
                    flash_en_d   = 1'b1;
                    flash_addr_d = BASE_ADDR + (WIDTH'(idx_q) << 2);
                    flash_data_d = WIDTH'(pk_word_nxt);
                end
            end

            WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_d == n_q) begin
`ifdef CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end

`ifdef CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
            flash_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            flash_addr_q <= flash_addr_d;
            flash_data_q <= flash_data_d;
            flash_en_q   <= flash_en_d;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: randomized byte streams against a word-list model.
module tb_mem_loader;

    localparam int          MAX_WORDS = 512;
    localparam logic [31:0] BASE      = 32'h0;
`ifdef CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, flash_en, cpu_hold, busy, done, error;
    logic [31:0] flash_addr, flash_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] stim_words[$];
    logic [31:0] mem[logic [31:0]];

    mem_loader #(
        .WIDTH     (32),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && flash_en) begin
            logic [63:0] e;
            chk("in_ready_in_write", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with nothing expected",
                         flash_addr, flash_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", flash_addr, e[63:32]);
                chk("write_data", flash_data, e[31:0]);
            end
            mem[flash_addr] = flash_data;
        end
    end

    function automatic bit gap_sel(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL byte_timeout: in_ready stayed 0 for byte 0x%02h", b);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(done || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(done || error)) begin
            n_checks++;
            $display("FAIL end_timeout: neither done nor error after load");
        end
    endtask

    // Model: words land at BASE+4*i; N>MAX is rejected; N==0 completes at once;
    // with the checksum build a wrong trailing XOR byte ends in error.
    task automatic do_load(input logic [31:0] n, input int gap_mode,
                           input bit bad_csum, input bit mid_start);
        bit          ok;
        bit          exp_err;
        logic [7:0]  x;
        logic [31:0] w;
        x       = 8'h00;
        ok      = (n <= MAX_WORDS);
        exp_err = !ok || (n != 0 && CSUM_ON && bad_csum);
        pulse_start();
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("hold_after_start", {31'b0, cpu_hold}, 32'd1);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gap_sel(gap_mode));
        if (ok && n != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                w = stim_words[i];
                exp_q.push_back({BASE + 32'(i) * 32'd4, w});
                for (int k = 0; k < 4; k++) begin
                    if (mid_start && i == 0 && k == 1) start = 1'b1;
                    send_byte(w[8*k +: 8], gap_sel(gap_mode));
                    start = 1'b0;
                    x ^= w[8*k +: 8];
                end
            end
            if (CSUM_ON) send_byte(bad_csum ? (x ^ 8'h01) : x, gap_sel(gap_mode));
        end
        wait_idle();
        @(negedge clk);
        chk("done", {31'b0, done}, {31'b0, !exp_err});
        chk("error", {31'b0, error}, {31'b0, exp_err});
        chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, exp_err});
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("in_ready_end", {31'b0, in_ready}, 32'd0);
        chk("writes_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        repeat (3) @(negedge clk);
        chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_flash_en", {31'b0, flash_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cpu_hold", {31'b0, cpu_hold}, 32'd1);

        // Basic three-word load, then read the memory model back.
        stim_words = '{32'h0001_2345, 32'h0006_789a, 32'hffff_ffff};
        do_load(32'd3, 0, 1'b0, 1'b0);
        chk("mem_rd0", mem[32'd0], 32'h0001_2345);
        chk("mem_rd4", mem[32'd4], 32'h0006_789a);
        chk("mem_rd8", mem[32'd8], 32'hffff_ffff);
        repeat (3) @(negedge clk);
        chk("done_holds", {31'b0, done}, 32'd1);

        // Same stream with in_valid toggled every other cycle.
        do_load(32'd3, 1, 1'b0, 1'b0);

        // Empty image and oversize headers.
        do_load(32'd0, 0, 1'b0, 1'b0);
        do_load(32'(MAX_WORDS + 1), 0, 1'b0, 1'b0);
        do_load(32'hffff_ff00, 2, 1'b0, 1'b0);

        // start pulsed mid-load is ignored; next start from DONE reloads at BASE.
        stim_words = '{32'hcafe_f00d, 32'h1357_9bdf};
        do_load(32'd2, 0, 1'b0, 1'b1);
        do_load(32'd2, 2, 1'b0, 1'b0);

        // Async reset after 2 of 3 words abandons the load.
        stim_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        pulse_start();
        n = 32'd3;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({BASE + 32'(i) * 32'd4, stim_words[i]});
            for (int k = 0; k < 4; k++) send_byte(stim_words[i][8*k +: 8], 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("partial_writes", exp_q.size(), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_flash_addr", flash_addr, 32'd0);
        chk("mid_rst_flash_data", flash_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        stim_words = '{32'hdead_beef};
        do_load(32'd1, 0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        stim_words = '{32'h0403_0201};
        do_load(32'd1, 0, 1'b0, 1'b0);
        do_load(32'd1, 0, 1'b1, 1'b0);
`endif

        // Randomized loads with random in_valid gaps.
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(1, 8);
            stim_words.delete();
            for (int i = 0; i < nw; i++) stim_words.push_back($urandom);
            do_load(32'(nw), 2, 1'b0, 1'b0);
        end

        // Largest legal image: last address is BASE + 4*(MAX_WORDS-1).
        stim_words.delete();
        for (int i = 0; i < MAX_WORDS; i++) stim_words.push_back($urandom);
        do_load(32'(MAX_WORDS), 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
